// File: rtl/ufm_dump_reader_pkg.sv
// Shared types and constants for the on-chip flash dump reader.
package ufm_dump_pkg;

    localparam int ADDR_W_DEF = 17;

    // Every flash access is a single-word read.
    localparam logic [1:0] BURST_ONE = 2'd1;

    typedef logic [1:0] byte_idx_t;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        SEND,
        FIN
    } state_t;

endpackage

// File: rtl/ufm_dump_reader_if.sv
// Flash data-port Avalon-MM read signals plus the outgoing byte stream.
// master: the dump reader. slave: flash IP together with the byte sink.
interface ufm_dump_reader_if
    import ufm_dump_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) ();

    logic [ADDR_W-1:0] avmm_data_addr;
    logic              avmm_data_read;
    logic [1:0]        avmm_data_burstcount;
    logic              avmm_data_waitrequest;
    logic              avmm_data_readdatavalid;
    logic [31:0]       avmm_data_readdata;

    logic [7:0]        out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output avmm_data_addr,
        output avmm_data_read,
        output avmm_data_burstcount,
        input  avmm_data_waitrequest,
        input  avmm_data_readdatavalid,
        input  avmm_data_readdata,
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  avmm_data_addr,
        input  avmm_data_read,
        input  avmm_data_burstcount,
        output avmm_data_waitrequest,
        output avmm_data_readdatavalid,
        output avmm_data_readdata,
        input  out_data,
        input  out_valid,
        output out_ready
    );

endinterface

// File: rtl/ufm_dump_reader_serializer.sv
// Splits one 32-bit word into four bytes, LSB first, on a valid/ready stream.
// last_sent pulses in the cycle the fourth byte is accepted.
module ufm_word_serializer
    import ufm_dump_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] word,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        last_sent
);

    logic [31:0] word_q;
    byte_idx_t   idx;
    logic        fire;

    assign fire      = out_valid & out_ready;
    assign last_sent = fire && (idx == 2'd3);

    // Byte select comes straight from registers, so it cannot change while stalled.
    assign out_data  = word_q[{idx, 3'b000} +: 8];

    // Word holding register, refreshed on each load.
    always_ff @(posedge clock) begin
        if (reset) begin
            word_q <= '0;
        end else if (load) begin
            word_q <= word;
        end
    end

    // Byte index and valid flag; advance only on an accepted byte.
    always_ff @(posedge clock) begin
        if (reset) begin
            idx       <= '0;
            out_valid <= 1'b0;
        end else if (load) begin
            idx       <= '0;
            out_valid <= 1'b1;
        end else if (fire) begin
            if (idx == 2'd3) begin
                out_valid <= 1'b0;
            end else begin
                idx <= idx + 2'd1;
            end
        end
    end

endmodule

// File: rtl/ufm_dump_reader.sv
// Sequential flash dump master: reads start_addr..end_addr one word at a
// time and streams each word out as four bytes.
module ufm_dump_reader
    import ufm_dump_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    output logic              busy,
    output logic              done,
    output logic              err,
    ufm_dump_reader_if.master bus
);

    localparam int              TO_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] cur;
    logic [ADDR_W-1:0] end_q;
    logic [TO_W-1:0]   to_cnt;
    logic              start_ok;
    logic              start_bad;
    logic              word_load;
    logic              timeout;
    logic              last_sent;
    logic              advance;

    // Next-state logic and single-cycle strobes.
    always_comb begin
        state_nx  = state;
        start_ok  = 1'b0;
        start_bad = 1'b0;
        word_load = 1'b0;
        timeout   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (end_addr < start_addr) begin
                        start_bad = 1'b1;
                    end else begin
                        start_ok = 1'b1;
                        state_nx = REQ;
                    end
                end
            end
            REQ: begin
                if (!bus.avmm_data_waitrequest) begin
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                if (bus.avmm_data_readdatavalid) begin
                    word_load = 1'b1;
                    state_nx  = SEND;
                end else if (to_cnt == TO_LAST) begin
                    timeout  = 1'b1;
                    state_nx = FIN;
                end
            end
            SEND: begin
                if (last_sent) begin
                    state_nx = (cur == end_q) ? FIN : REQ;
                end
            end
            FIN: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Equality with end_q stops the walk, so end_addr at the top of the map never wraps.
    assign advance = (state == SEND) && last_sent && (cur != end_q);

    // Current and last word address, latched on an accepted start.
    always_ff @(posedge clock) begin
        if (reset) begin
            cur   <= '0;
            end_q <= '0;
        end else if (start_ok) begin
            cur   <= start_addr;
            end_q <= end_addr;
        end else if (advance) begin
            cur <= cur + 1'b1;
        end
    end

    // Read-latency timer: counts WAIT cycles from zero, cleared elsewhere.
    always_ff @(posedge clock) begin
        if (reset || (state != WAIT)) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // Done pulse and sticky error flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            done <= 1'b0;
            err  <= 1'b0;
        end else begin
            done <= start_bad || (state_nx == FIN);
            if (start_bad || timeout) begin
                err <= 1'b1;
            end else if (start_ok) begin
                err <= 1'b0;
            end
        end
    end

    assign busy                     = (state != IDLE);
    assign bus.avmm_data_read       = (state == REQ);
    assign bus.avmm_data_addr       = cur;
    assign bus.avmm_data_burstcount = BURST_ONE;

    ufm_word_serializer u_ser (
        .clock     (clock),
        .reset     (reset),
        .load      (word_load),
        .word      (bus.avmm_data_readdata),
        .out_data  (bus.out_data),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .last_sent (last_sent)
    );

endmodule

// File: tb/tb_ufm_dump_reader.sv
// Self-checking bench for ufm_dump_reader: behavioural flash + byte sink,
// table-driven dumps, hand-written reset/ignored-start sequences, random dumps.
module tb_ufm_dump_reader;
    import ufm_dump_pkg::*;

    localparam int AW = 17;
    localparam int TO = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] start_addr;
    logic [AW-1:0] end_addr;
    logic          busy;
    logic          done;
    logic          err;

    ufm_dump_reader_if #(.ADDR_W(AW)) bus ();

    ufm_dump_reader #(.ADDR_W(AW), .TIMEOUT_CYC(TO)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .start_addr (start_addr),
        .end_addr   (end_addr),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .bus        (bus)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Configuration written only by the main sequence.
    int wait_cycles;
    int latency;
    bit rdv_en;
    int ready_mode;
    bit inj_rdv;
    bit clear_req;

    // Observations written only by the flash/sink process.
    int            cyc;
    logic [AW-1:0] reads[$];
    logic [7:0]    byte_q[$];
    int            acc_cyc, last_xfer_cyc, done_cyc, done_cnt;
    int            n_hold_viol, n_overlap_viol, n_stream_viol;
    int            stall_cnt, lat_cnt;
    bit            stalled, pending, prev_stall;
    logic [AW-1:0] stall_addr, pend_addr;
    logic [7:0]    prev_data;
    logic          ready_new;

    // Flash contents: one fixed word for the first table entry, arithmetic elsewhere.
    function automatic logic [31:0] mem_word(int a);
        if (a == 32'h10) return 32'hA1B2C3D4;
        return (32'h9E3779B9 * (a + 1)) ^ 32'h5A5A0000;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Flash responder and byte sink; acts on the falling edge.
    initial begin : flash_and_sink
        bus.avmm_data_waitrequest   = 1'b0;
        bus.avmm_data_readdatavalid = 1'b0;
        bus.avmm_data_readdata      = '0;
        bus.out_ready               = 1'b0;
        cyc = 0; done_cnt = 0; done_cyc = -1; acc_cyc = -1; last_xfer_cyc = -1;
        n_hold_viol = 0; n_overlap_viol = 0; n_stream_viol = 0;
        stall_cnt = 0; lat_cnt = 0; stalled = 0; pending = 0; prev_stall = 0;
        stall_addr = '0; pend_addr = '0; prev_data = '0; ready_new = 1'b0;
        forever begin
            @(negedge clock);
            cyc++;
            if (clear_req) begin
                reads.delete(); byte_q.delete();
                done_cnt = 0; done_cyc = -1; acc_cyc = -1; last_xfer_cyc = -1;
                n_hold_viol = 0; n_overlap_viol = 0; n_stream_viol = 0;
                stall_cnt = 0; pending = 0;
            end
            bus.avmm_data_readdatavalid = 1'b0;
            if (inj_rdv) begin
                bus.avmm_data_readdatavalid = 1'b1;
                bus.avmm_data_readdata      = 32'hDEADBEEF;
            end else if (pending) begin
                lat_cnt--;
                if (lat_cnt == 0) begin
                    bus.avmm_data_readdatavalid = 1'b1;
                    bus.avmm_data_readdata      = mem_word(int'(pend_addr));
                    pending = 0;
                end
            end
            if (stalled && (bus.avmm_data_read !== 1'b1 || bus.avmm_data_addr !== stall_addr))
                n_hold_viol++;
            stalled = 0;
            bus.avmm_data_waitrequest = 1'b0;
            if (bus.avmm_data_read === 1'b1) begin
                if (bus.out_valid === 1'b1) n_overlap_viol++;
                if (stall_cnt < wait_cycles) begin
                    bus.avmm_data_waitrequest = 1'b1;
                    stall_cnt++;
                    stalled    = 1;
                    stall_addr = bus.avmm_data_addr;
                end else begin
                    stall_cnt = 0;
                    reads.push_back(bus.avmm_data_addr);
                    acc_cyc = cyc;
                    if (rdv_en) begin
                        pending   = 1;
                        lat_cnt   = latency;
                        pend_addr = bus.avmm_data_addr;
                    end
                end
            end
            case (ready_mode)
                0:       ready_new = 1'b1;
                1:       ready_new = ~bus.out_ready;
                default: ready_new = 1'($urandom_range(0, 1));
            endcase
            if (prev_stall && (bus.out_valid !== 1'b1 || bus.out_data !== prev_data))
                n_stream_viol++;
            if (bus.out_valid === 1'b1 && ready_new) begin
                byte_q.push_back(bus.out_data);
                last_xfer_cyc = cyc;
            end
            prev_stall    = (bus.out_valid === 1'b1) && !ready_new;
            prev_data     = bus.out_data;
            bus.out_ready = ready_new;
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    typedef struct {
        logic [AW-1:0] sa;
        logic [AW-1:0] ea;
        int            wait_cycles;
        int            latency;
        int            ready_mode;
        bit            rdv_en;
        bit            exp_err;
        int            exp_nreads;
        int            exp_nbytes;
    } vec_t;

    vec_t vecs[8];

    task automatic clear_mon();
        clear_req = 1'b1;
        tick(1);
        clear_req = 1'b0;
    endtask

    task automatic pulse_start(logic [AW-1:0] sa, logic [AW-1:0] ea);
        start_addr = sa;
        end_addr   = ea;
        start      = 1'b1;
        tick(1);
        start      = 1'b0;
    endtask

    task automatic wait_done(int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done_cnt > 0) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
    endtask

    task automatic run_vec(input vec_t v);
        bit            ok;
        logic [AW-1:0] exp_reads[$];
        logic [7:0]    exp_bytes[$];
        logic [31:0]   w;
        wait_cycles = v.wait_cycles;
        latency     = v.latency;
        rdv_en      = v.rdv_en;
        ready_mode  = v.ready_mode;
        clear_mon();
        pulse_start(v.sa, v.ea);
        if (v.ea >= v.sa) begin
            chk("start_busy", busy, 1);
            chk("start_err_clear", err, 0);
        end else begin
            chk("bad_range_busy", busy, 0);
            chk("bad_range_done_now", done, 1);
            chk("bad_range_err_now", err, 1);
        end
        wait_done(3000, ok);
        chk("done_seen", ok, 1);
        tick(4);
        chk("err", err, v.exp_err);
        chk("busy_after", busy, 0);
        chk("done_count", done_cnt, 1);
        chk("n_reads", reads.size(), v.exp_nreads);
        chk("n_bytes", byte_q.size(), v.exp_nbytes);
        chk("addr_held_in_stall", n_hold_viol, 0);
        chk("read_while_bytes", n_overlap_viol, 0);
        chk("byte_held_in_stall", n_stream_viol, 0);
        if (v.ea >= v.sa) begin
            for (int a = int'(v.sa); a <= int'(v.ea); a++) begin
                exp_reads.push_back(AW'(a));
                if (!v.rdv_en) break;
                w = mem_word(a);
                for (int b = 0; b < 4; b++) exp_bytes.push_back(8'(w >> (8 * b)));
            end
        end
        for (int i = 0; i < reads.size() && i < exp_reads.size(); i++)
            chk("read_addr", reads[i], exp_reads[i]);
        for (int i = 0; i < byte_q.size() && i < exp_bytes.size(); i++)
            chk("byte", byte_q[i], exp_bytes[i]);
        if (v.exp_nbytes > 0)
            chk("done_after_last_byte", done_cyc, last_xfer_cyc + 1);
        if (!v.rdv_en && v.exp_nreads > 0)
            chk("timeout_done_delay", done_cyc - acc_cyc, TO + 1);
    endtask

    initial begin : main
        bit   ok;
        vec_t rv;
        int   len;
        reset = 1'b1; start = 1'b0; start_addr = '0; end_addr = '0;
        clear_req = 1'b0; inj_rdv = 1'b0;
        wait_cycles = 0; latency = 1; rdv_en = 1'b1; ready_mode = 0;
        tick(3);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_read", bus.avmm_data_read, 0);
        chk("rst_addr", bus.avmm_data_addr, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("burstcount", bus.avmm_data_burstcount, 1);
        reset = 1'b0;
        tick(2);

        //          sa         ea         wait lat rdy rdv err rd  by
        vecs[0] = '{17'h00010, 17'h00010, 0,   3,  0,  1,  0,  1,  4};
        vecs[1] = '{17'h00000, 17'h00003, 5,   2,  0,  1,  0,  4,  16};
        vecs[2] = '{17'h00020, 17'h00021, 1,   1,  1,  1,  0,  2,  8};
        vecs[3] = '{17'h00030, 17'h00030, 0,   1,  0,  0,  1,  1,  0};
        vecs[4] = '{17'h1FFFE, 17'h1FFFF, 0,   1,  2,  1,  0,  2,  8};
        vecs[5] = '{17'h00005, 17'h00002, 0,   1,  0,  1,  1,  0,  0};
        vecs[6] = '{17'h1FFFF, 17'h1FFFF, 2,   2,  1,  1,  0,  1,  4};
        vecs[7] = '{17'h00000, 17'h00000, 0,   5,  2,  1,  0,  1,  4};
        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Reset while waiting for read data, then a late readdatavalid.
        rdv_en = 1'b0; wait_cycles = 0; ready_mode = 0;
        clear_mon();
        pulse_start(17'h40, 17'h40);
        tick(4);
        chk("wait_busy", busy, 1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("mid_rst_read", bus.avmm_data_read, 0);
        chk("mid_rst_out_valid", bus.out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        inj_rdv = 1'b1;
        tick(1);
        inj_rdv = 1'b0;
        tick(10);
        chk("late_rdv_bytes", byte_q.size(), 0);
        chk("late_rdv_busy", busy, 0);
        chk("late_rdv_done", done_cnt, 0);

        // A second start while busy must not disturb the running dump.
        rdv_en = 1'b1; latency = 4; wait_cycles = 1; ready_mode = 0;
        clear_mon();
        pulse_start(17'h50, 17'h51);
        tick(2);
        pulse_start(17'h60, 17'h60);
        chk("ignored_start_busy", busy, 1);
        wait_done(3000, ok);
        chk("ignored_start_done_seen", ok, 1);
        tick(4);
        chk("ignored_start_n_reads", reads.size(), 2);
        if (reads.size() == 2) begin
            chk("ignored_start_addr0", reads[0], 17'h50);
            chk("ignored_start_addr1", reads[1], 17'h51);
        end
        chk("ignored_start_n_bytes", byte_q.size(), 8);
        chk("ignored_start_done_count", done_cnt, 1);

        // Random ranges, stalls, latencies and sink back-pressure.
        for (int i = 0; i < 24; i++) begin
            len            = int'($urandom_range(1, 3));
            rv.sa          = AW'($urandom_range(0, 1000));
            rv.ea          = rv.sa + AW'(len - 1);
            rv.wait_cycles = int'($urandom_range(0, 3));
            rv.latency     = int'($urandom_range(1, 5));
            rv.ready_mode  = int'($urandom_range(0, 2));
            rv.rdv_en      = 1'b1;
            rv.exp_err     = 1'b0;
            rv.exp_nreads  = len;
            rv.exp_nbytes  = 4 * len;
            run_vec(rv);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ufm_dump_reader.md
Name: ufm_dump_reader

Overview:
- Sequential read master for the on-chip flash Avalon-MM data port; sits directly upstream of the flash IP.
- On a start pulse it reads a word range, one single-word read at a time (burstcount = 1).
- Each 32-bit word is serialised into a byte stream with valid/ready handshake, for the UART/USB dump path.
- Reports done and error status to the control logic.

Parameters:
- ADDR_W, 17, flash data-port word address width.
- TIMEOUT_CYC, 1024, max cycles from read accept to readdatavalid before abort.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a dump when idle.
- start_addr  in  ADDR_W  first word address; latched on accepted start.
- end_addr  in  ADDR_W  last word address, inclusive; latched on accepted start.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at end of dump (normal or abort).
- err  out  1  sticky error flag; cleared on the next accepted start.
- avmm_data_addr  out  ADDR_W  flash read address.
- avmm_data_read  out  1  read request.
- avmm_data_burstcount  out  2  constant 2'd1.
- avmm_data_waitrequest  in  1  flash stall.
- avmm_data_readdatavalid  in  1  read data valid.
- avmm_data_readdata  in  32  read data.
- out_data  out  8  stream byte.
- out_valid  out  1  stream byte valid.
- out_ready  in  1  downstream accepts byte.

Behaviour:
- Reset values: busy = 0, done = 0, err = 0, avmm_data_read = 0, avmm_data_addr = 0, out_valid = 0, out_data = 0, state IDLE.
- Reset mid-dump: the next edge returns to IDLE and drops read/out_valid. A late readdatavalid after reset is ignored.
- FSM transitions:
  - IDLE: on start, latch start/end_addr, set cur = start_addr, clear err, go to REQ.
    - If end_addr < start_addr, set err = 1, pulse done, stay IDLE.
    - start while not IDLE is ignored.
  - REQ: drive read = 1 and addr = cur; hold both stable while waitrequest = 1.
    - The cycle with waitrequest = 0 is the accept. Deassert read next cycle, go to WAIT.
  - WAIT: timeout counter runs from 0.
    - On readdatavalid, capture readdata into the word register and go to SEND.
    - If the counter reaches TIMEOUT_CYC-1 without valid, set err = 1 and go to FIN.
    - readdatavalid in the same cycle as the accept is not possible with burstcount 1; it is ignored outside WAIT.
  - SEND: emit 4 bytes LSB first (word[7:0], [15:8], [23:16], [31:24]).
    - out_valid is high while a byte is pending. out_data holds stable while out_valid & !out_ready.
    - A byte transfers on out_valid & out_ready.
    - After byte 3 transfers: if cur == end_addr go to FIN, else cur = cur + 1 and go to REQ.
    - No read is issued while bytes are pending. Throughput is bounded by flash latency plus 4 byte cycles.
  - FIN: done = 1 for one cycle, busy = 0 from the next cycle, go to IDLE.
- Address arithmetic: ADDR_W-bit unsigned. end_addr = 2^ADDR_W - 1 terminates on the equality compare and never wraps.
- busy = (state != IDLE).

Decomposition:
- Package ufm_dump_pkg:
  - state enum (IDLE, REQ, WAIT, SEND, FIN).
  - ADDR_W default.
  - byte-index type (2 bits).
  - BURST_ONE constant 2'd1.
- Sub-module ufm_word_serializer:
  - Inputs: 32-bit word with load strobe.
  - Outputs: 8-bit valid/ready stream and a last-byte-sent pulse.
- The top level keeps the FSM, address counter and timeout counter.

Test Plan:
1. Reset, then start with start_addr = 0x10, end_addr = 0x10; flash returns 0xA1B2C3D4 three cycles after accept; out_ready = 1 -> bytes D4, C3, B2, A1 in order; done pulse one cycle after the A1 transfer; err = 0; exactly one read issued at addr 0x10.
2. Range 0x00..0x03 with waitrequest held high 5 cycles on each request -> addr/read held stable during stall; 4 reads at 0,1,2,3; 16 bytes out; single done pulse.
3. out_ready toggled 1010… in SEND -> out_data stable while stalled; no byte duplicated or dropped; no read issued until the 4th byte transfers.
4. Never assert readdatavalid, TIMEOUT_CYC = 16 -> err = 1 and done pulse 16 cycles after accept; a subsequent start clears err.
5. start_addr = 5, end_addr = 2 -> immediate done pulse, err = 1, no avmm_data_read.
6. Assert reset during WAIT, then inject readdatavalid -> read = 0, out_valid = 0, busy = 0; no byte emitted; start pulse while busy in a later dump is ignored.
